// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity-type codes, line levels
// and a counter-width helper, used by the transmitter and its receiver twin.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // Bits needed to hold values 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel request side and serial line of the UART transmitter, grouped so the
// producer (master) and the transmitter (slave) share one connection.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data, data_valid, par_en, par_typ,
    input  tx_out, busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ,
    output tx_out, busy
  );

endinterface

// File: rtl/uart_tx_baud_counter.sv
// Bit-period (prescale) and data-bit counters for the transmitter; both wrap to
// zero at their terminal count and are held at zero while their phase is inactive.
module uart_tx_baud_counter
  import uart_pkg::*;
#(
  parameter int PRESCALE   = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  input  logic data_phase_i,
  output logic bit_done_o,
  output logic last_bit_o
);

  localparam int PW = cnt_width(PRESCALE);
  localparam int BW = cnt_width(DATA_WIDTH);
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [BW-1:0] BIT_MAX   = BW'(DATA_WIDTH - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] bit_q, bit_d;

  assign bit_done_o = (presc_q == PRESC_MAX);
  assign last_bit_o = (bit_q == BIT_MAX);

  always_comb begin
    presc_d = presc_q;
    bit_d   = bit_q;
    if (!run_i) begin
      presc_d = '0;
    end else if (bit_done_o) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end
    // The bit index only advances when a data bit has run its full period.
    if (!data_phase_i) begin
      bit_d = '0;
    end else if (bit_done_o) begin
      bit_d = last_bit_o ? '0 : bit_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      bit_q   <= '0;
    end else begin
      presc_q <= presc_d;
      bit_q   <= bit_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave bus
);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  bit_done;
  logic                  last_bit;
  logic                  accept;
`ifdef UART_TX_PARITY_EN
  logic                  par_en_q, par_en_d;
  logic                  parity_q, parity_d;
`endif

  uart_tx_baud_counter #(
    .PRESCALE   (PRESCALE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_baud (
    .clk          (clk),
    .reset        (reset),
    .run_i        (state_q != IDLE),
    .data_phase_i (state_q == DATA),
    .bit_done_o   (bit_done),
    .last_bit_o   (last_bit)
  );

  // busy_q is low for exactly the IDLE cycles, so this also gates requests mid-frame.
  assign accept = bus.data_valid && !busy_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
`ifdef UART_TX_PARITY_EN
    par_en_d = par_en_q;
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          data_d  = bus.p_data;
`ifdef UART_TX_PARITY_EN
          par_en_d = bus.par_en;
          parity_d = (^bus.p_data) ^ (bus.par_typ == PAR_ODD);
`endif
        end
      end
      START: begin
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        if (bit_done) begin
          if (last_bit) begin
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end else begin
            data_d = data_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Line level is decoded from the next state so tx_out is a clean register.
    tx_d = LINE_IDLE;
    case (state_d)
      START:   tx_d = START_BIT;
      DATA:    tx_d = data_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = LINE_IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      tx_q    <= LINE_IDLE;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q <= 1'b0;
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_en_q <= par_en_d;
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.tx_out = tx_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: every frame is checked cycle by cycle against a
// hand-built bit pattern; expectations follow the UART_TX_PARITY_EN build option.
module tb_uart_tx;

  localparam int P = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  uart_tx_if #(.DATA_WIDTH(8)) bus ();

  uart_tx #(
    .DATA_WIDTH (8),
    .PRESCALE   (P)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int frame_bits(input logic pe);
`ifdef UART_TX_PARITY_EN
    return pe ? 11 : 10;
`else
    return 10;
`endif
  endfunction

  // Serial frame LSB first: start, data, optional hand-computed parity bit, stop.
  function automatic logic [15:0] frame(input logic [7:0] d, input logic pe, input logic par_bit);
`ifdef UART_TX_PARITY_EN
    if (pe) return {5'b0, 1'b1, par_bit, d, 1'b0};
`endif
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  // Called at a negedge in an idle cycle; returns at the negedge of the idle cycle after the frame.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic pe, input logic pt,
                           input logic [15:0] exp_frame, input int nbits, input int glitch_k);
    int busy_cnt;
    busy_cnt = 0;
    bus.p_data     = d;
    bus.par_en     = pe;
    bus.par_typ    = pt;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    bus.p_data     = ~d;
    bus.par_en     = ~pe;
    bus.par_typ    = ~pt;
    for (int k = 0; k < nbits * P; k++) begin
      if (k == glitch_k) begin
        bus.data_valid = 1'b1;
        bus.p_data     = 8'h3C;
      end
      if (glitch_k >= 0 && k == glitch_k + 3) bus.data_valid = 1'b0;
      check($sformatf("%s tx c%0d", tag, k), 32'(bus.tx_out), 32'(exp_frame[k / P]));
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
    end
    check($sformatf("%s busy_len", tag), 32'(busy_cnt), 32'(nbits * P));
    check($sformatf("%s idle_tx", tag), 32'(bus.tx_out), 32'd1);
    check($sformatf("%s idle_busy", tag), 32'(bus.busy), 32'd0);
    $display("frame %s data %02h par_en %0d par_typ %0d bits %0d busy_cycles %0d",
             tag, d, pe, pt, nbits, busy_cnt);
  endtask

  initial begin
    bus.p_data     = 8'h00;
    bus.data_valid = 1'b0;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    reset          = 1'b0;

    repeat (2) @(negedge clk);
    check("rst tx", 32'(bus.tx_out), 32'd1);
    check("rst busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    check("post_rst tx", 32'(bus.tx_out), 32'd1);
    check("post_rst busy", 32'(bus.busy), 32'd0);

    // First request lands on the first edge after reset release.
    run_frame("a5_even", 8'hA5, 1'b1, 1'b0, frame(8'hA5, 1'b1, 1'b0), frame_bits(1'b1), -1);
    run_frame("01_odd", 8'h01, 1'b1, 1'b1, frame(8'h01, 1'b1, 1'b0), frame_bits(1'b1), -1);
    run_frame("01_even", 8'h01, 1'b1, 1'b0, frame(8'h01, 1'b1, 1'b1), frame_bits(1'b1), -1);
    run_frame("ff_nopar", 8'hFF, 1'b0, 1'b0, frame(8'hFF, 1'b0, 1'b0), frame_bits(1'b0), -1);
    // 0x3C requested mid-frame is dropped, then requested again on the first idle cycle.
    run_frame("81_glitch", 8'h81, 1'b0, 1'b0, frame(8'h81, 1'b0, 1'b0), frame_bits(1'b0), 30);
    run_frame("3c_next", 8'h3C, 1'b1, 1'b0, frame(8'h3C, 1'b1, 1'b0), frame_bits(1'b1), -1);

    // Reset in the middle of data bit 4 (a zero bit of 0x0F).
    bus.p_data     = 8'h0F;
    bus.par_en     = 1'b1;
    bus.par_typ    = 1'b0;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    repeat (5 * P + 3) @(negedge clk);
    check("pre_abort tx", 32'(bus.tx_out), 32'd0);
    check("pre_abort busy", 32'(bus.busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("abort tx", 32'(bus.tx_out), 32'd1);
    check("abort busy", 32'(bus.busy), 32'd0);
    $display("abort reset mid data bit 4 tx %0d busy %0d", bus.tx_out, bus.busy);
    @(negedge clk);
    reset = 1'b1;
    run_frame("0f_after_rst", 8'h0F, 1'b1, 1'b0, frame(8'h0F, 1'b1, 1'b0), frame_bits(1'b1), -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: payload bits per frame.
REQ-002 SHALL have parameter PRESCALE, default 8: clk cycles per bit, legal range 4..32, matching the receiver oversampling ratio.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port p_data  input  DATA_WIDTH  parallel payload, sampled on acceptance.
REQ-006 SHALL have port data_valid  input  1  payload request, single-cycle or held.
REQ-007 SHALL have port par_en  input  1  parity bit enable, sampled on acceptance.
REQ-008 SHALL have port par_typ  input  1  parity type, 0 = even, 1 = odd, sampled on acceptance.
REQ-009 SHALL have port tx_out  output  1  serial line, registered, idle high.
REQ-010 SHALL have port busy  output  1  frame in progress, registered.

Function
REQ-011 SHALL accept a frame only in a cycle where data_valid=1 and busy=0; data_valid while busy=1 SHALL be ignored, with no queueing.
REQ-012 SHALL latch p_data, par_en and par_typ on acceptance; later input changes SHALL NOT affect the frame in flight.
REQ-013 SHALL use FSM states IDLE, START, DATA, PARITY, STOP: IDLE->START on acceptance; START->DATA, DATA->PARITY (par_en latched 1) or STOP (latched 0), PARITY->STOP, STOP->IDLE, each after its bit period completes.
REQ-014 SHALL hold each bit on tx_out for exactly PRESCALE clk cycles, timed by a prescale counter running 0..PRESCALE-1.
REQ-015 SHALL count data bits 0..DATA_WIDTH-1 with a bit counter; DATA SHALL exit after bit DATA_WIDTH-1 has run its full period.
REQ-016 SHALL drive tx_out = 0 in START, latched data LSB first in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
REQ-017 SHALL compute parity as the XOR of all latched data bits for even parity, and its inverse for odd parity.
REQ-018 SHALL drive tx_out low and busy high starting the cycle after acceptance (latency 1).
REQ-019 SHALL hold busy high through the last STOP cycle, then drive it low in the first IDLE cycle, so that at least one IDLE cycle separates frames.
REQ-020 SHALL produce a frame length of (DATA_WIDTH+2+par_en)*PRESCALE cycles, plus 1 IDLE cycle before the next acceptance.
REQ-021 SHALL size the prescale and bit counters to hold PRESCALE-1 and DATA_WIDTH-1 without overflow, and wrap both to 0 at each terminal count.

Reset
REQ-022 SHALL, while reset is low, force state IDLE, tx_out=1, busy=0, both counters 0 and the data latch to 0.
REQ-023 SHALL abort any frame when reset is asserted mid-operation, with tx_out returning high immediately and asynchronously.
REQ-024 SHALL, after reset deassertion, accept data_valid in the first clk edge.

Configuration
REQ-025 SHALL, when macro UART_TX_PARITY_EN is defined, implement the PARITY state and honour par_en and par_typ.
REQ-026 SHALL, when UART_TX_PARITY_EN is undefined, omit the PARITY state and parity logic, keep par_en and par_typ ports unconnected internally, and always produce DATA_WIDTH+2 bit frames.

Structure
REQ-027 SHALL take from shared package uart_pkg the FSM state typedef, the parity-type constants PAR_EVEN and PAR_ODD, and the line levels LINE_IDLE=1 and START_BIT=0.
REQ-028 SHALL place the prescale and bit counters in sub-module uart_tx_baud_counter, the transmit counterpart of the receiver's edge/bit counter; the FSM and shift logic SHALL remain in uart_tx.

Verification
REQ-029 Bench SHALL cover: reset, then p_data=0xA5, par_en=1, par_typ=0 -> tx_out 0,1,0,1,0,0,1,0,1,0(parity),1, each held 8 cycles; busy high for 88 cycles.
REQ-030 Bench SHALL cover: p_data=0x01, par_en=1, par_typ=1 -> parity bit 0; same data with par_typ=0 -> parity bit 1.
REQ-031 Bench SHALL cover: par_en=0, p_data=0xFF -> 10-bit frame, 80 cycles busy, no parity slot.
REQ-032 Bench SHALL cover: second data_valid with 0x3C asserted mid-frame -> ignored and first frame unchanged; 0x3C reasserted on first busy=0 cycle -> accepted, start bit follows next cycle.
REQ-033 Bench SHALL cover: reset pulsed low during bit 4 of DATA -> tx_out=1 and busy=0 immediately; next frame is correct.
REQ-034 Bench SHALL cover: build with UART_TX_PARITY_EN undefined, par_en=1 -> 10-bit frame, 80 cycles.
